// File: rtl/line_merge_scheduler_pkg.sv
// lms_pkg: shared constants, FSM states and the board cell-index helper for line_merge_scheduler.
package lms_pkg;
    localparam int DIR_LEFT  = 0;
    localparam int DIR_RIGHT = 1;
    localparam int DIR_UP    = 2;
    localparam int DIR_DOWN  = 3;
    localparam int CELL_W    = 4;
    localparam int LINES     = 4;
    localparam int LINE_W    = CELL_W * LINES;
    localparam int BOARD_W   = LINE_W * LINES;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;

    // Element 0 is the slide destination, so right/down walk the line backwards.
    function automatic logic [3:0] cell_idx(input logic [3:0] dir, input logic [1:0] k, input logic [1:0] e);
        logic [1:0] p;
        logic       vert;
        p    = (dir[DIR_RIGHT] | dir[DIR_DOWN]) ? ~e : e;
        vert = ~(dir[DIR_LEFT] | dir[DIR_RIGHT]);
        return vert ? {p, k} : {k, p};
    endfunction
endpackage

// File: rtl/line_merge_scheduler_if.sv
// line_merge_scheduler_if: issue/response handshake between the scheduler and the shared line merger.
interface line_merge_scheduler_if
    import lms_pkg::*;
#(
    parameter int GAIN_W = 16
);
    logic              mrg_req_valid;
    logic              mrg_req_ready;
    logic [LINE_W-1:0] mrg_line_out;
    logic              mrg_resp_valid;
    logic [LINE_W-1:0] mrg_line_in;
    logic [GAIN_W-1:0] mrg_gain_in;

    modport master (
        output mrg_req_valid, mrg_line_out,
        input  mrg_req_ready, mrg_resp_valid, mrg_line_in, mrg_gain_in
    );
    modport slave (
        input  mrg_req_valid, mrg_line_out,
        output mrg_req_ready, mrg_resp_valid, mrg_line_in, mrg_gain_in
    );
endinterface

// File: rtl/line_merge_scheduler_line_map.sv
// lms_line_map: gathers line k of a board for a direction and scatters a merged line back at the same cells.
module lms_line_map
    import lms_pkg::*;
(
    input  logic [3:0]         dir_i,
    input  logic [1:0]         k_i,
    input  logic [BOARD_W-1:0] src_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [LINE_W-1:0]  line_i,
    input  logic [BOARD_W-1:0] base_i,
    output logic [BOARD_W-1:0] board_o
);
    always_comb begin
        line_o  = '0;
        board_o = base_i;
        for (int e = 0; e < LINES; e++) begin
            line_o[e*CELL_W +: CELL_W]                            = src_i[{cell_idx(dir_i, k_i, 2'(e)), 2'b00} +: CELL_W];
            board_o[{cell_idx(dir_i, k_i, 2'(e)), 2'b00} +: CELL_W] = line_i[e*CELL_W +: CELL_W];
        end
    end
endmodule

// File: rtl/line_merge_scheduler.sv
// line_merge_scheduler: runs one 4x4 move through a single time-shared line merger and commits changed boards.
// Optional LMS_TIMEOUT_EN aborts a move whose merger response does not arrive within TIMEOUT_CYC cycles.
module line_merge_scheduler
    import lms_pkg::*;
#(
    parameter int GAIN_W      = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [3:0]            req_dir,
    output logic                  req_ready,
    input  logic [BOARD_W-1:0]    board_in,
    line_merge_scheduler_if.master mrg,
    output logic [BOARD_W-1:0]    board_out,
    output logic                  board_we,
    output logic                  done,
    output logic                  moved,
    output logic [GAIN_W-1:0]     score_gain,
    output logic                  err
);
`ifdef LMS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    state_t             state_q, state_d;
    logic [1:0]         k_q, k_d;
    logic [3:0]         dir_q, dir_d;
    logic [BOARD_W-1:0] snap_q, snap_d, work_q, work_d, bo_q, bo_d, scat;
    logic [GAIN_W-1:0]  acc_q, acc_d, score_q, score_d;
    logic [GAIN_W:0]    sum;
    logic [TW-1:0]      cnt_q, cnt_d;
    logic               we_q, we_d, done_q, done_d, moved_q, moved_d, err_q, err_d;

    lms_line_map u_map (
        .dir_i  (dir_q),
        .k_i    (k_q),
        .src_i  (snap_q),
        .line_o (mrg.mrg_line_out),
        .line_i (mrg.mrg_line_in),
        .base_i (work_q),
        .board_o(scat)
    );

    assign sum               = {1'b0, acc_q} + {1'b0, mrg.mrg_gain_in};
    assign req_ready         = state_q == IDLE;
    assign mrg.mrg_req_valid = state_q == ISSUE;
    assign board_out         = bo_q;
    assign board_we          = we_q;
    assign done              = done_q;
    assign moved             = moved_q;
    assign score_gain        = score_q;
    assign err               = err_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        dir_d   = dir_q;
        snap_d  = snap_q;
        work_d  = work_q;
        bo_d    = bo_q;
        acc_d   = acc_q;
        score_d = score_q;
        cnt_d   = cnt_q;
        moved_d = moved_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                if ($onehot(req_dir)) begin
                    state_d = ISSUE;
                    dir_d   = req_dir;
                    snap_d  = board_in;
                    work_d  = board_in;
                    acc_d   = '0;
                    k_d     = '0;
                end else begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    moved_d = 1'b0;
                    score_d = '0;
                end
            end
            ISSUE: if (mrg.mrg_req_ready) begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: if (mrg.mrg_resp_valid) begin
                work_d  = scat;
                acc_d   = sum[GAIN_W] ? '1 : sum[GAIN_W-1:0];
                k_d     = k_q + 2'd1;
                state_d = (k_q == 2'd3) ? COMMIT : ISSUE;
                // Outputs register on entry so they are visible during the COMMIT cycle.
                if (k_q == 2'd3) begin
                    moved_d = scat != snap_q;
                    we_d    = moved_d;
                    bo_d    = moved_d ? scat : bo_q;
                    done_d  = 1'b1;
                    score_d = acc_d;
                end
            end else if (TMO_EN && cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
                err_d   = 1'b1;
                moved_d = 1'b0;
                score_d = '0;
            end else begin
                cnt_d = cnt_q + TW'(1);
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            dir_q   <= '0;
            snap_q  <= '0;
            work_q  <= '0;
            bo_q    <= '0;
            acc_q   <= '0;
            score_q <= '0;
            cnt_q   <= '0;
            moved_q <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            dir_q   <= dir_d;
            snap_q  <= snap_d;
            work_q  <= work_d;
            bo_q    <= bo_d;
            acc_q   <= acc_d;
            score_q <= score_d;
            cnt_q   <= cnt_d;
            moved_q <= moved_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_line_merge_scheduler.sv
// tb_line_merge_scheduler: directed and random moves against a board-level reference model with a stalling merger.
module tb_line_merge_scheduler;
    logic        clk, rst, req_valid, req_ready, board_we, done, moved, err;
    logic [3:0]  req_dir;
    logic [63:0] board_in, board_out;
    logic [15:0] score_gain;

    int checks = 0, failures = 0;
    int m_stall = 0, m_lat = 1, stall_bad = 0, busy_bad = 0;
    logic [15:0] m_gain_ovr = '0;
    int we_cnt = 0, done_cnt = 0, hs_cnt = 0;
    logic [63:0] exp_board = '0;

    line_merge_scheduler_if #(.GAIN_W(16)) mrg ();

    line_merge_scheduler #(.GAIN_W(16), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_dir(req_dir), .req_ready(req_ready),
        .board_in(board_in), .mrg(mrg), .board_out(board_out), .board_we(board_we),
        .done(done), .moved(moved), .score_gain(score_gain), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (board_we === 1'b1) we_cnt <= we_cnt + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (mrg.mrg_req_valid === 1'b1 && mrg.mrg_req_ready === 1'b1) hs_cnt <= hs_cnt + 1;
    end

    // 2048 rule: slide non-empty cells to element 0, merge equal neighbours once, gain = new tile value.
    function automatic void merge_line(input logic [15:0] li, output logic [15:0] lo, output int g);
        int q[$];
        int i, n;
        lo = '0;
        g  = 0;
        n  = 0;
        i  = 0;
        for (int e = 0; e < 4; e++) if (li[e*4 +: 4] != 0) q.push_back(int'(li[e*4 +: 4]));
        while (i < q.size()) begin
            if (i + 1 < q.size() && q[i] == q[i+1]) begin
                lo[n*4 +: 4] = 4'(q[i] + 1);
                g += 1 << (q[i] + 1);
                i += 2;
            end else begin
                lo[n*4 +: 4] = 4'(q[i]);
                i += 1;
            end
            n++;
        end
    endfunction

    function automatic void ref_move(input logic [3:0] dir, input logic [63:0] b, output logic [63:0] nb, output longint g);
        logic [15:0] li, lo;
        int lg, r, c;
        int idx[4];
        nb = b;
        g  = 0;
        for (int k = 0; k < 4; k++) begin
            for (int e = 0; e < 4; e++) begin
                case (dir)
                    4'b0001: begin r = k;     c = e;     end
                    4'b0010: begin r = k;     c = 3 - e; end
                    4'b0100: begin r = e;     c = k;     end
                    default: begin r = 3 - e; c = k;     end
                endcase
                idx[e] = r * 4 + c;
                li[e*4 +: 4] = b[idx[e]*4 +: 4];
            end
            merge_line(li, lo, lg);
            g += lg;
            for (int e = 0; e < 4; e++) nb[idx[e]*4 +: 4] = lo[e*4 +: 4];
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin : merger
        logic [15:0] held, lo;
        int g;
        mrg.mrg_req_ready  = 1'b0;
        mrg.mrg_resp_valid = 1'b0;
        mrg.mrg_line_in    = '0;
        mrg.mrg_gain_in    = '0;
        forever begin
            @(negedge clk);
            mrg.mrg_req_ready  = 1'b0;
            mrg.mrg_resp_valid = 1'b0;
            if (mrg.mrg_req_valid === 1'b1) begin
                held = mrg.mrg_line_out;
                for (int i = 0; i < m_stall; i++) begin
                    @(negedge clk);
                    if (mrg.mrg_line_out !== held || mrg.mrg_req_valid !== 1'b1) stall_bad++;
                end
                mrg.mrg_req_ready = 1'b1;
                @(negedge clk);
                mrg.mrg_req_ready = 1'b0;
                for (int i = 1; i < m_lat; i++) @(negedge clk);
                merge_line(held, lo, g);
                mrg.mrg_line_in    = lo;
                mrg.mrg_gain_in    = (m_gain_ovr != 0) ? m_gain_ovr : 16'(g);
                mrg.mrg_resp_valid = 1'b1;
            end
        end
    end

    task automatic run_move(input string tag, input logic [3:0] dir, input logic [63:0] b, input bit poke, output int n);
        logic [63:0] nb;
        longint g;
        int we0, hs0;
        ref_move(dir, b, nb, g);
        if (m_gain_ovr != 0) g = 4 * longint'(m_gain_ovr);
        if (g > 65535) g = 65535;
        we0 = we_cnt;
        hs0 = hs_cnt;
        chk({tag, " req_ready_idle"}, req_ready, 1'b1);
        board_in  = b;
        req_dir   = dir;
        req_valid = 1'b1;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            req_valid = poke && n < 5;
            req_dir   = poke ? 4'b1000 : dir;
            board_in  = {$urandom, $urandom};
            if (poke && n < 5 && req_ready !== 1'b0) busy_bad++;
            if (done === 1'b1) break;
        end
        req_valid = 1'b0;
        if (nb != b) exp_board = nb;
        chk({tag, " done"}, done, 1'b1);
        chk({tag, " board_out"}, board_out, exp_board);
        chk({tag, " moved"}, moved, nb != b);
        chk({tag, " board_we"}, board_we, nb != b);
        chk({tag, " score_gain"}, score_gain, 64'(g));
        chk({tag, " err"}, err, 1'b0);
        @(negedge clk);
        chk({tag, " req_ready_after"}, req_ready, 1'b1);
        chk({tag, " done_pulse"}, done, 1'b0);
        chk({tag, " we_count"}, we_cnt - we0, (nb != b) ? 1 : 0);
        chk({tag, " issues"}, hs_cnt - hs0, 4);
    endtask

    initial begin : stim
        int n, hs0, we0, d0;
        logic [63:0] b;
        rst = 1'b0;
        req_valid = 1'b0;
        req_dir = '0;
        board_in = '0;
        repeat (3) @(negedge clk);
        chk("reset req_ready", req_ready, 1'b1);
        chk("reset outputs", {board_out, board_we, done, moved, err, mrg.mrg_req_valid, score_gain}, '0);
        rst = 1'b1;
        @(negedge clk);

        run_move("left_latency", 4'b0001, 64'h11, 1'b0, n);
        chk("left_latency cycles", n, 9);
        chk("left_latency board", board_out, 64'h2);

        run_move("right_nomove", 4'b0010, 64'h1000_1000_1000_1000, 1'b0, n);
        chk("right_nomove board", board_out, 64'h2);

        m_stall = 3;
        run_move("up_stall", 4'b0100, 64'h0020_0000_0020_0000, 1'b0, n);
        chk("up_stall board", board_out, 64'h30);
        chk("up_stall stable", stall_bad, 0);
        m_stall = 0;

        hs0 = hs_cnt;
        req_valid = 1'b1;
        req_dir = 4'b0101;
        @(negedge clk);
        req_valid = 1'b0;
        chk("illegal done", done, 1'b1);
        chk("illegal err", err, 1'b1);
        chk("illegal moved", moved, 1'b0);
        chk("illegal score", score_gain, 0);
        chk("illegal we", board_we, 1'b0);
        chk("illegal no issue", mrg.mrg_req_valid, 1'b0);
        req_valid = 1'b1;
        req_dir = 4'b0000;
        @(negedge clk);
        req_valid = 1'b0;
        chk("zero_dir err", {done, err}, 2'b11);
        repeat (3) @(negedge clk);
        chk("illegal issues", hs_cnt - hs0, 0);
        chk("illegal board", board_out, exp_board);

        m_lat = 2;
        run_move("busy_poke", 4'b0001, 64'h0000_0000_2200_0110, 1'b1, n);
        chk("busy req_ready low", busy_bad, 0);

        m_lat = 6;
        hs0 = hs_cnt;
        we0 = we_cnt;
        d0 = done_cnt;
        board_in = 64'h0000_3300_1100_0022;
        req_dir = 4'b0001;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (hs_cnt < hs0 + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst reach line2", hs_cnt - hs0, 3);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst req_ready", req_ready, 1'b1);
        chk("midrst outputs", {board_out, board_we, done, moved, err, mrg.mrg_req_valid, score_gain}, '0);
        rst = 1'b1;
        exp_board = '0;
        repeat (12) @(negedge clk);
        chk("midrst no write", we_cnt - we0, 0);
        chk("midrst no done", done_cnt - d0, 0);
        m_lat = 1;
        run_move("after_rst", 4'b1000, 64'h0000_0001_0000_0001, 1'b0, n);

        m_gain_ovr = 16'hC000;
        run_move("saturate", 4'b0010, 64'h0000_0000_0000_0011, 1'b0, n);
        m_gain_ovr = '0;

        for (int t = 0; t < 12; t++) begin
            m_stall = $urandom_range(0, 2);
            m_lat = $urandom_range(1, 3);
            for (int c = 0; c < 16; c++) b[c*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 4));
            run_move("random", 4'b0001 << $urandom_range(0, 3), b, 1'b0, n);
        end
        chk("final stall stable", stall_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/line_merge_scheduler.md
Name: line_merge_scheduler

Overview:
Sequences one move of the 4x4 board through a single shared line-merge unit, one line at a time.
- Snapshots the board on an accepted move request.
- Issues the four lines in direction-specific order to the merger and scatters the merged lines back.
- Accumulates merge gain and commits the new board only if the move changed something.
- Sits between the button/move decode and the board register file; replaces four parallel mergers with one time-shared unit.

Parameters:
GAIN_W, 16, width of per-line gain and accumulated score_gain
TIMEOUT_CYC, 64, max cycles in WAIT before abort (used only with LMS_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
req_valid  in  1  move request
req_dir  in  4  one-hot direction: bit0 left, bit1 right, bit2 up, bit3 down
req_ready  out  1  high when state==IDLE
board_in  in  64  live board; cell i = bits [4i+3:4i], i=row*4+col, row0 top, col0 left, 4-bit exponent, 0=empty
mrg_req_valid  out  1  line issue valid
mrg_req_ready  in  1  merger accepts line
mrg_line_out  out  16  line to merger; element e = bits [4e+3:4e], element0 = slide destination
mrg_resp_valid  in  1  one-cycle result pulse
mrg_line_in  in  16  merged line, same element order
mrg_gain_in  in  GAIN_W  gain for that line
board_out  out  64  committed board
board_we  out  1  one-cycle write strobe
done  out  1  one-cycle completion pulse
moved  out  1  board changed by last move
score_gain  out  GAIN_W  summed gain of last move
err  out  1  one-cycle abort/illegal pulse

Behaviour:
- Reset (rst==0 at posedge): state IDLE, line counter 0; board_out, board_we, done, moved, score_gain, err, mrg_req_valid all 0. Applies mid-operation; in-flight merge discarded, no write.
- States: IDLE, ISSUE, WAIT, COMMIT.
- IDLE: req_ready=1. On req_valid:
  - One-hot req_dir: snapshot board_in, clear accumulator, k=0, go to ISSUE.
  - Any other req_dir (zero or multi-bit): pulse done and err next cycle; moved=0, score_gain=0, no board_we; stay IDLE.
- ISSUE: mrg_req_valid=1 with line k; hold line stable until mrg_req_ready; on handshake go to WAIT.
- Line k, elements e0..e3:
  - left: row k, col0..3
  - right: row k, col3..0
  - up: col k, row0..3
  - down: col k, row3..0
- WAIT: ignore everything until mrg_resp_valid. On mrg_resp_valid:
  - Scatter mrg_line_in into working board at the same positions.
  - Accumulate gain; sum saturates at all-ones.
  - k<3: k++, go to ISSUE. k==3: go to COMMIT.
- mrg_resp_valid outside WAIT is ignored; a response in the same cycle as the issue handshake is ignored.
- COMMIT (one cycle):
  - moved = (working != snapshot); done=1; score_gain=accumulator.
  - If moved: board_out=working and board_we=1. Otherwise board_out unchanged and board_we=0.
  - Return to IDLE.
- Latency, with mrg_req_ready=1 and response one cycle after issue: accept in cycle 0, done/board_we in cycle 9, req_ready in cycle 10.
- req_valid while not IDLE: ignored, not queued.
- board_in changes after snapshot: no effect on the current move.

Optional Feature:
LMS_TIMEOUT_EN:
- Defined: a cycle counter runs in WAIT. Reaching TIMEOUT_CYC → err and done pulse, moved=0, no board_we, go to IDLE.
- Undefined: WAIT waits indefinitely and err fires only for illegal req_dir.

Decomposition:
- Package lms_pkg holds:
  - direction bit indices (DIR_LEFT=0, DIR_RIGHT=1, DIR_UP=2, DIR_DOWN=3)
  - state encodings
  - CELL_W=4, LINES=4
  - a cell-index function (dir, line, element) -> 0..15
- Sub-module lms_line_map: combinational gather/scatter of one line from/to a 64-bit board given dir and k; reused for issue and write-back.

Test Plan:
- Reference merger model: line exponents [1,1,0,0] → [2,0,0,0], gain 4; stalls and latencies are randomisable.
- Left, row0=[1,1,0,0], rest 0, zero-wait merger → done in cycle 9, board_we=1, board_out row0=[2,0,0,0], moved=1, score_gain=4.
- Right on board with every row [0,0,0,1] → four issues, done=1, moved=0, board_we=0, board_out unchanged.
- Up, column1=[0,2,0,2] top-down, mrg_req_ready low 3 cycles on each line → mrg_line_out held stable while stalled; column1 becomes [3,0,0,0], score_gain=8.
- req_dir=4'b0101 → done+err next cycle, moved=0, no mrg_req_valid; then req_valid during a busy move is ignored and req_ready stays 0.
- Reset asserted in WAIT for line 2 → next cycle IDLE, all outputs 0, no board_we; next legal request completes normally.
- LMS_TIMEOUT_EN with TIMEOUT_CYC=8 and merger silent → err+done 8 cycles after entering WAIT, board_we never asserted.
